// File: rtl/face_result_tx_sched_pkg.sv
// rtl/face_result_tx_sched_pkg.sv - shared record type, FSM states and constants for the result tx scheduler
package face_result_tx_sched_pkg;

    localparam int BYTE_W       = 8;
    localparam int RECORD_BYTES = 5;

    // found sits in the MSBs so the record leaves the shift register MSB-first
    typedef struct packed {
        logic [BYTE_W-1:0] found;
        logic [BYTE_W-1:0] c0;
        logic [BYTE_W-1:0] r0;
        logic [BYTE_W-1:0] c1;
        logic [BYTE_W-1:0] r1;
    } face_rec_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        ACK,
        DRAIN
    } tx_state_t;

    localparam face_rec_t TERM_REC = '0;

    function automatic face_rec_t make_face_rec(
        input logic [BYTE_W-1:0] c0,
        input logic [BYTE_W-1:0] r0,
        input logic [BYTE_W-1:0] c1,
        input logic [BYTE_W-1:0] r1
    );
        face_rec_t rec;
        rec.found = 8'h01;
        rec.c0    = c0;
        rec.r0    = r0;
        rec.c1    = c1;
        rec.r1    = r1;
        return rec;
    endfunction

endpackage

// File: rtl/face_result_tx_sched_if.sv
// rtl/face_result_tx_sched_if.sv - face result handshake and UART transmitter signals
interface face_result_tx_sched_if #(
    parameter int COORD_W = 8
);
    logic               face_valid;
    logic               face_ready;
    logic [COORD_W-1:0] face_r0;
    logic [COORD_W-1:0] face_c0;
    logic [COORD_W-1:0] face_r1;
    logic [COORD_W-1:0] face_c1;
    logic               frame_done;
    logic               uart_cts;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic               tx_busy;

    modport slave (
        input  face_valid, face_r0, face_c0, face_r1, face_c1,
        input  frame_done, uart_cts, tx_busy,
        output face_ready, tx_data, tx_start
    );

    modport master (
        output face_valid, face_r0, face_c0, face_r1, face_c1,
        output frame_done, uart_cts, tx_busy,
        input  face_ready, tx_data, tx_start
    );
endinterface

// File: rtl/face_result_tx_sched_sync_fifo.sv
// rtl/face_result_tx_sched_sync_fifo.sv - single-clock record FIFO with full/empty flags
module sync_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // a full FIFO may still take a write when a read frees the slot that cycle
    assign do_wr   = wr_en && (!full || rd_en);
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/face_result_tx_sched.sv
// rtl/face_result_tx_sched.sv - queues face results and serialises 5-byte records onto the UART tx engine
module face_result_tx_sched
    import face_result_tx_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int COORD_W    = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    face_result_tx_sched_if.slave  bus,
    output logic                   overflow,
    output logic [15:0]            records_sent
);
    localparam int REC_W = $bits(face_rec_t);
    localparam logic [2:0] LAST_IDX = 3'(RECORD_BYTES - 1);

    logic             full;
    logic             empty;
    logic             term_pending;
    logic             push_face;
    logic             push_term;
    logic             fifo_wr;
    face_rec_t        fifo_din;
    face_rec_t        fifo_dout;

    tx_state_t        state;
    tx_state_t        next_state;
    logic             fire;
    logic             pop;
    logic             drain_step;
    logic             last_byte;
    logic [REC_W-1:0] shift_reg;
    logic [2:0]       byte_idx;
    logic [7:0]       tx_data_q;
    logic             tx_start_q;

    // faces are refused while a terminator waits so it cannot be overtaken
    assign bus.face_ready = !full && !term_pending;
    assign push_face      = bus.face_valid && bus.face_ready;
    assign push_term      = term_pending && !full;
    assign fifo_wr        = push_face || push_term;
    assign fifo_din       = push_face ? make_face_rec(8'(bus.face_c0), 8'(bus.face_r0),
                                                      8'(bus.face_c1), 8'(bus.face_r1))
                                      : TERM_REC;

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data (fifo_din),
        .rd_en   (pop),
        .rd_data (fifo_dout),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            term_pending <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            if (bus.frame_done && term_pending) begin
                overflow <= 1'b1;
            end
            if (bus.frame_done && !term_pending) begin
                term_pending <= 1'b1;
            end else if (push_term) begin
                term_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!empty) next_state = LOAD;
            LOAD:    next_state = SEND;
            SEND:    if (fire) next_state = ACK;
            ACK:     next_state = DRAIN;
            DRAIN:   if (drain_step) next_state = last_byte ? IDLE : SEND;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        fire       = (state == SEND) && bus.uart_cts && !bus.tx_busy;
        pop        = (state == LOAD);
        drain_step = (state == DRAIN) && !bus.tx_busy;
        last_byte  = (byte_idx == LAST_IDX);
    end

    // strobe and byte are registered together so tx_data is stable under tx_start
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_reg    <= '0;
            byte_idx     <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            records_sent <= '0;
        end else begin
            tx_start_q <= fire;
            if (pop) begin
                shift_reg <= fifo_dout;
                byte_idx  <= '0;
            end
            if (fire) begin
                tx_data_q <= shift_reg[REC_W-1 -: 8];
            end
            if (drain_step) begin
                if (last_byte) begin
                    records_sent <= records_sent + 16'd1;
                end else begin
                    byte_idx  <= byte_idx + 3'd1;
                    shift_reg <= shift_reg << 8;
                end
            end
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;
endmodule
